// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the main-memory arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration instead of fixed dcache priority.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned BEATS_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  // Beat counter width; a single-beat burst still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way combinational picker between icache and dcache requests.
// Build option: MEM_ARB_RR_EN adds a round-robin pointer input used to break ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       ic_valid,
  input  logic       dc_valid,
`ifdef MEM_ARB_RR_EN
  input  owner_t     rr_ptr,
`endif
  output logic [1:0] grant_c,
  output owner_t     winner_c
);

  always_comb begin
    winner_c = OWN_DC;
    grant_c  = 2'b00;
`ifdef MEM_ARB_RR_EN
    if (ic_valid && dc_valid) begin
      winner_c = rr_ptr;
    end else if (ic_valid) begin
      winner_c = OWN_IC;
    end
`else
    if (ic_valid && !dc_valid) begin
      winner_c = OWN_IC;
    end
`endif
    grant_c[0] = (ic_valid || dc_valid) && (winner_c == OWN_IC);
    grant_c[1] = (ic_valid || dc_valid) && (winner_c == OWN_DC);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between icache fills and dcache fills/writebacks.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration (default: dcache priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BEATS  = BEATS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ic_req_valid,
  output logic                ic_req_ready,
  input  logic [ADDR_W-1:0]   ic_req_addr,
  output logic                ic_resp_valid,
  output logic [DATA_W-1:0]   ic_resp_data,
  input  logic                dc_req_valid,
  output logic                dc_req_ready,
  input  logic                dc_req_rw,
  input  logic [ADDR_W-1:0]   dc_req_addr,
  input  logic                dc_wdata_valid,
  output logic                dc_wdata_ready,
  input  logic [DATA_W-1:0]   dc_wdata,
  input  logic [DATA_W/8-1:0] dc_wmask,
  output logic                dc_resp_valid,
  output logic [DATA_W-1:0]   dc_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_wdata_valid,
  input  logic                mem_wdata_ready,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy,
  output logic                arb_err
);

  localparam int unsigned CNT_W = cnt_width(BEATS);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [1:0]        grant_c;
  owner_t            winner_c;
  logic              last_beat_c;
`ifdef MEM_ARB_RR_EN
  owner_t            rr_q, rr_d;
`endif

  mem_arb_pick u_pick (
    .ic_valid (ic_req_valid),
    .dc_valid (dc_req_valid),
`ifdef MEM_ARB_RR_EN
    .rr_ptr   (rr_q),
`endif
    .grant_c  (grant_c),
    .winner_c (winner_c)
  );

  // State and transaction context registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IC;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_q    <= OWN_DC;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef MEM_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Next-state, handshake steering and beat counting.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    rw_d            = rw_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
`ifdef MEM_ARB_RR_EN
    rr_d            = rr_q;
`endif
    ic_req_ready    = 1'b0;
    dc_req_ready    = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_rw      = rw_q;
    mem_req_addr    = addr_q;
    mem_wdata_valid = 1'b0;
    dc_wdata_ready  = 1'b0;
    mem_wdata       = dc_wdata;
    mem_wmask       = dc_wmask;
    ic_resp_valid   = 1'b0;
    dc_resp_valid   = 1'b0;
    ic_resp_data    = mem_resp_data;
    dc_resp_data    = mem_resp_data;
    last_beat_c     = (cnt_q == CNT_W'(BEATS - 1));

    // A read beat with no read burst open is a protocol error and is dropped.
    if (mem_resp_valid && (state_q != ST_RDATA)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        ic_req_ready = grant_c[0];
        dc_req_ready = grant_c[1];
        if (grant_c != 2'b00) begin
          owner_d = winner_c;
          addr_d  = (winner_c == OWN_DC) ? dc_req_addr : ic_req_addr;
          rw_d    = (winner_c == OWN_DC) && dc_req_rw;
`ifdef MEM_ARB_RR_EN
          rr_d    = (winner_c == OWN_DC) ? OWN_IC : OWN_DC;
`endif
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = rw_q ? ST_WDATA : ST_RDATA;
        end
      end
      ST_WDATA: begin
        mem_wdata_valid = dc_wdata_valid;
        dc_wdata_ready  = mem_wdata_ready;
        if (dc_wdata_valid && mem_wdata_ready) begin
          cnt_d = last_beat_c ? '0 : cnt_q + CNT_W'(1);
          if (last_beat_c) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RDATA: begin
        ic_resp_valid = mem_resp_valid && (owner_q == OWN_IC);
        dc_resp_valid = mem_resp_valid && (owner_q == OWN_DC);
        if (mem_resp_valid) begin
          cnt_d = last_beat_c ? '0 : cnt_q + CNT_W'(1);
          if (last_beat_c) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign arb_err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model.
// Honors MEM_ARB_RR_EN to select the expected arbitration rule.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned MASK_W = DATA_W / 8;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              ic_req_valid, ic_req_ready;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_resp_valid;
  logic [DATA_W-1:0] ic_resp_data;
  logic              dc_req_valid, dc_req_ready, dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              dc_wdata_valid, dc_wdata_ready;
  logic [DATA_W-1:0] dc_wdata;
  logic [MASK_W-1:0] dc_wmask;
  logic              dc_resp_valid;
  logic [DATA_W-1:0] dc_resp_data;
  logic              mem_req_valid, mem_req_ready, mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_wdata_valid, mem_wdata_ready;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              busy, arb_err;

  int errors = 0;
  int checks = 0;
  int m_ptr;   // model tie-break pointer: 1 = dcache, 0 = icache
  bit m_err;   // model sticky error

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
    .dc_wdata(dc_wdata), .dc_wmask(dc_wmask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid),
    .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .arb_err(arb_err)
  );

  // Winner by rule: lone requester wins; ties go to dcache or to the pointer.
  function automatic int model_pick(input bit ic_v, input bit dc_v);
    if (ic_v && dc_v) return RR_EN ? m_ptr : 1;
    return dc_v ? 1 : 0;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic clear_inputs();
    ic_req_valid = 0; ic_req_addr = '0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
    dc_wdata_valid = 0; dc_wdata = '0; dc_wmask = '0;
    mem_req_ready = 0; mem_wdata_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic apply_reset();
    reset = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1;
    m_ptr = 1;
    m_err = 0;
  endtask

  // One complete transaction; mode 1 uses the fixed addresses/data/ready pattern.
  task automatic run_txn(input bit ic_v, input bit dc_v, input bit dc_rw,
                         input int stall, input int mode, output int winner);
    logic [ADDR_W-1:0] ic_a, dc_a, exp_addr;
    logic [DATA_W-1:0] d;
    bit exp_rw;
    bit pat [6];
    int w, done, cyc, gap;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    ic_a = (mode == 1) ? ADDR_W'(32'h0000100) : ADDR_W'($urandom);
    dc_a = (mode == 1) ? ADDR_W'(32'h0000200) : ADDR_W'($urandom);
    ic_req_valid = ic_v; ic_req_addr = ic_a;
    dc_req_valid = dc_v; dc_req_rw = dc_rw; dc_req_addr = dc_a;
    w = model_pick(ic_v, dc_v);
    winner = w;
    exp_addr = (w == 1) ? dc_a : ic_a;
    exp_rw = (w == 1) ? dc_rw : 1'b0;
    m_ptr = RR_EN ? (1 - w) : m_ptr;
    #1;
    checks++;
    if ({dc_req_ready, ic_req_ready} !== ((w == 1) ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL grant: dc/ic ready=%b expected %b", {dc_req_ready, ic_req_ready},
               (w == 1) ? 2'b10 : 2'b01);
    end
    @(posedge clk); #1;
    ic_req_valid = 0; dc_req_valid = 0;
    for (int k = 0; k < stall; k++) begin
      ic_req_valid = 1; dc_req_valid = 1; mem_req_ready = 0;
      #1;
      checks++;
      if ({mem_req_valid, mem_req_rw, mem_req_addr} !== {1'b1, exp_rw, exp_addr}) begin
        errors++;
        $display("FAIL cmd_stall: valid/rw/addr=%b/%b/%h expected 1/%b/%h",
                 mem_req_valid, mem_req_rw, mem_req_addr, exp_rw, exp_addr);
      end
      checks++;
      if ({ic_req_ready, dc_req_ready} !== 2'b00) begin
        errors++;
        $display("FAIL ready_in_cmd: ic/dc ready=%b expected 00", {ic_req_ready, dc_req_ready});
      end
      @(posedge clk); #1;
    end
    ic_req_valid = 0; dc_req_valid = 0; mem_req_ready = 1;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_rw, mem_req_addr, busy} !== {1'b1, exp_rw, exp_addr, 1'b1}) begin
      errors++;
      $display("FAIL cmd: valid/rw/addr/busy=%b/%b/%h/%b expected 1/%b/%h/1",
               mem_req_valid, mem_req_rw, mem_req_addr, busy, exp_rw, exp_addr);
    end
    @(posedge clk); #1;
    mem_req_ready = 0;
    if (exp_rw) begin
      done = 0; cyc = 0;
      while (done < int'(BEATS) && cyc < 64) begin
        if (mode == 1) begin
          dc_wdata_valid = 1; mem_wdata_ready = pat[cyc % 6];
        end else begin
          dc_wdata_valid = ($urandom_range(3) != 0) || (cyc >= 16);
          mem_wdata_ready = ($urandom_range(3) != 0) || (cyc >= 16);
        end
        dc_wdata = rand_data(); dc_wmask = MASK_W'($urandom);
        #1;
        checks++;
        if ({mem_wdata_valid, dc_wdata_ready, mem_wdata, mem_wmask, ic_resp_valid, dc_resp_valid, busy}
            !== {dc_wdata_valid, mem_wdata_ready, dc_wdata, dc_wmask, 1'b0, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL wbeat%0d: wv/wr/busy=%b/%b/%b data=%h mask=%h expected %b/%b/1 data=%h mask=%h",
                   done, mem_wdata_valid, dc_wdata_ready, busy, mem_wdata, mem_wmask,
                   dc_wdata_valid, mem_wdata_ready, dc_wdata, dc_wmask);
        end
        if (dc_wdata_valid && mem_wdata_ready) done++;
        cyc++;
        @(posedge clk); #1;
      end
      dc_wdata_valid = 0; mem_wdata_ready = 0;
    end else begin
      for (int b = 0; b < int'(BEATS); b++) begin
        gap = (mode == 1) ? 0 : $urandom_range(2);
        for (int g = 0; g < gap; g++) begin
          mem_resp_valid = 0;
          #1;
          checks++;
          if ({ic_resp_valid, dc_resp_valid, busy} !== 3'b001) begin
            errors++;
            $display("FAIL rgap: ic/dc resp/busy=%b expected 001", {ic_resp_valid, dc_resp_valid, busy});
          end
          @(posedge clk); #1;
        end
        d = (mode == 1) ? DATA_W'(32'hA0 + b) : rand_data();
        mem_resp_valid = 1; mem_resp_data = d;
        #1;
        checks++;
        if ({ic_resp_valid, dc_resp_valid} !== ((w == 1) ? 2'b01 : 2'b10) ||
            ((w == 1) ? dc_resp_data : ic_resp_data) !== d) begin
          errors++;
          $display("FAIL rbeat%0d: ic/dc valid=%b data=%h expected %b data=%h", b,
                   {ic_resp_valid, dc_resp_valid}, (w == 1) ? dc_resp_data : ic_resp_data,
                   (w == 1) ? 2'b01 : 2'b10, d);
        end
        @(posedge clk); #1;
      end
      mem_resp_valid = 0;
    end
    #1;
    checks++;
    if ({busy, mem_req_valid, mem_wdata_valid, ic_resp_valid, dc_resp_valid, arb_err}
        !== {5'b00000, m_err}) begin
      errors++;
      $display("FAIL txn_end: busy/reqv/wv/icr/dcr/err=%b expected 00000%b",
               {busy, mem_req_valid, mem_wdata_valid, ic_resp_valid, dc_resp_valid, arb_err}, m_err);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if ({busy, ic_req_ready, dc_req_ready, mem_req_valid, mem_wdata_valid, dc_wdata_ready,
         ic_resp_valid, dc_resp_valid, arb_err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: outputs=%b expected 000000000",
               {busy, ic_req_ready, dc_req_ready, mem_req_valid, mem_wdata_valid, dc_wdata_ready,
                ic_resp_valid, dc_resp_valid, arb_err});
    end
  endtask

  task automatic test_ic_read();
    int w;
    run_txn(1, 0, 0, 0, 1, w);
  endtask

  task automatic test_dc_write();
    int w;
    run_txn(0, 1, 1, 0, 1, w);
  endtask

  task automatic test_cmd_stall();
    int w;
    run_txn(1, 0, 0, 5, 0, w);
    run_txn(0, 1, 1, 5, 0, w);
  endtask

  task automatic test_tie();
    int w;
    bit exp_dc;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      exp_dc = RR_EN ? (i % 2 == 0) : 1'b1;
      ic_req_valid = 1; dc_req_valid = 1; dc_req_rw = 0;
      #1;
      checks++;
      if ({dc_req_ready, ic_req_ready} !== {exp_dc, ~exp_dc}) begin
        errors++;
        $display("FAIL tie%0d: dc/ic ready=%b expected %b", i, {dc_req_ready, ic_req_ready},
                 {exp_dc, ~exp_dc});
      end
      run_txn(1, 1, 1'($urandom_range(1)), 0, 0, w);
    end
  endtask

  task automatic test_err();
    int w;
    mem_resp_valid = 1; mem_resp_data = rand_data();
    #1;
    checks++;
    if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL err_drop: ic/dc resp=%b expected 00", {ic_resp_valid, dc_resp_valid});
    end
    @(posedge clk); #1;
    mem_resp_valid = 0;
    m_err = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (arb_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: arb_err=%b expected 1", arb_err);
    end
    run_txn(1, 0, 0, 1, 0, w);
    apply_reset();
    #1;
    checks++;
    if (arb_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: arb_err=%b expected 0", arb_err);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    ic_req_valid = 1; ic_req_addr = ADDR_W'($urandom);
    @(posedge clk); #1;
    ic_req_valid = 0; mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_valid = 1; mem_resp_data = rand_data();
      @(posedge clk); #1;
    end
    mem_resp_valid = 1; reset = 0;
    @(posedge clk); #1;
    reset = 1; mem_resp_valid = 0;
    m_ptr = 1; m_err = 0;
    #1;
    checks++;
    if ({busy, mem_req_valid, ic_resp_valid, dc_resp_valid, mem_wdata_valid, ic_req_ready,
         dc_req_ready, arb_err} !== 8'b0) begin
      errors++;
      $display("FAIL reset_mid: outputs=%b expected 00000000",
               {busy, mem_req_valid, ic_resp_valid, dc_resp_valid, mem_wdata_valid, ic_req_ready,
                dc_req_ready, arb_err});
    end
    run_txn(1, 0, 0, 0, 1, w);
  endtask

  task automatic test_random();
    int w, sel;
    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(1, 3);
      run_txn(sel[0], sel[1], 1'($urandom_range(1)), $urandom_range(3), 0, w);
      if ($urandom_range(1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    test_reset();
    test_ic_read();
    test_dc_write();
    test_cmd_stall();
    test_tie();
    test_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
